// File: rtl/fulladder_chk.sv
// Exhaustive full-adder checker: drives all eight {a,b,cin} vectors to an external
// combinational DUT, waits SETTLE cycles per vector, compares sum/cout and reports.
module fulladder_chk #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       ina,
    output logic       inb,
    output logic       cin,
    input  logic       sum,
    input  logic       cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] first_err_vec
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_t     state_q, state_d;
    logic [2:0] vidx_q, vidx_d;
    logic [3:0] wait_q, wait_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] err_q, err_d;
    logic [2:0] first_q, first_d;
    logic       pass_q, pass_d;

    logic exp_sum, exp_cout, mismatch;

    // Expected response comes from the registered drive, not from vidx, so the
    // comparison always matches what the DUT actually saw.
    always_comb begin
        exp_sum  = vec_q[2] ^ vec_q[1] ^ vec_q[0];
        exp_cout = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
        mismatch = (sum != exp_sum) || (cout != exp_cout);
    end

    always_comb begin
        state_d = state_q;
        vidx_d  = vidx_q;
        wait_d  = wait_q;
        vec_d   = vec_q;
        err_d   = err_q;
        first_d = first_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_APPLY;
                    vidx_d  = 3'd0;
                    vec_d   = 3'd0;
                    err_d   = 4'd0;
                    first_d = 3'd0;
                    pass_d  = 1'b0;
                end
            end
            S_APPLY: begin
                wait_d  = 4'd0;
                state_d = (SETTLE > 0) ? S_SETTLE : S_CHECK;
            end
            S_SETTLE: begin
                if (wait_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                    wait_d  = 4'd0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + 4'd1;
                    if (err_q == 4'd0) first_d = vidx_q;
                end
                if (vidx_q == 3'd7) begin
                    state_d = S_DONE;
                    vec_d   = 3'd0;
                end else begin
                    state_d = S_APPLY;
                    vidx_d  = vidx_q + 3'd1;
                    vec_d   = vidx_q + 3'd1;
                end
            end
            S_DONE: begin
                pass_d  = (err_q == 4'd0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vidx_q  <= 3'd0;
            wait_q  <= 4'd0;
            vec_q   <= 3'd0;
            err_q   <= 4'd0;
            first_q <= 3'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vidx_q  <= vidx_d;
            wait_q  <= wait_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            first_q <= first_d;
            pass_q  <= pass_d;
        end
    end

    assign ina           = vec_q[2];
    assign inb           = vec_q[1];
    assign cin           = vec_q[0];
    assign busy          = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done          = (state_q == S_DONE);
    assign pass          = pass_q;
    assign err_cnt       = err_q;
    assign first_err_vec = first_q;

endmodule

// File: tb/tb_fulladder_chk.sv
// Directed bench: two checker instances (SETTLE=2 and SETTLE=0) driving a
// behavioural full adder with selectable faults.
module tb_fulladder_chk;

    logic clk = 1'b0;
    logic rst_n;
    logic start2, start0;
    int   fault;  // 0 correct, 1 cout stuck-at-0, 2 sum inverted

    logic ina2, inb2, cin2, sum2, cout2, busy2, done2, pass2;
    logic [3:0] err2;
    logic [2:0] fev2;
    logic ina0, inb0, cin0, sum0, cout0, busy0, done0, pass0;
    logic [3:0] err0;
    logic [2:0] fev0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        sum2  = (fault == 2) ? ~(ina2 ^ inb2 ^ cin2) : (ina2 ^ inb2 ^ cin2);
        cout2 = (fault == 1) ? 1'b0 : ((ina2 & inb2) | (ina2 & cin2) | (inb2 & cin2));
        sum0  = (fault == 2) ? ~(ina0 ^ inb0 ^ cin0) : (ina0 ^ inb0 ^ cin0);
        cout0 = (fault == 1) ? 1'b0 : ((ina0 & inb0) | (ina0 & cin0) | (inb0 & cin0));
    end

    fulladder_chk #(.SETTLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .ina(ina2), .inb(inb2), .cin(cin2), .sum(sum2), .cout(cout2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .first_err_vec(fev2)
    );

    fulladder_chk #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .ina(ina0), .inb(inb0), .cin(cin0), .sum(sum0), .cout(cout0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .first_err_vec(fev0)
    );

    // selected-instance view for the shared sweep task
    logic       sel0;
    logic       m_busy, m_done, m_pass;
    logic [2:0] m_vec, m_fev;
    logic [3:0] m_err;
    always_comb begin
        m_busy = sel0 ? busy0 : busy2;
        m_done = sel0 ? done0 : done2;
        m_pass = sel0 ? pass0 : pass2;
        m_vec  = sel0 ? {ina0, inb0, cin0} : {ina2, inb2, cin2};
        m_fev  = sel0 ? fev0 : fev2;
        m_err  = sel0 ? err0 : err2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel0) start0 = v;
        else      start2 = v;
    endtask

    // Pulse (or hold) start, then follow the sweep to its done pulse.
    // lat = edges from the start-sampling edge to the cycle with done high.
    task automatic run_sweep(input bit hold, output int lat, output int busy_n,
                             output logic [23:0] seq);
        logic [2:0] last;
        bit         have;
        have   = 0;
        last   = 3'd0;
        seq    = 24'd0;
        busy_n = 0;
        lat    = 0;
        @(negedge clk) set_start(1'b1);
        @(negedge clk) if (!hold) set_start(1'b0);
        while (lat < 300) begin
            if (m_busy) begin
                busy_n++;
                if (!have || m_vec != last) seq = {seq[20:0], m_vec};
                have = 1;
                last = m_vec;
            end
            if (m_done) break;
            @(negedge clk);
            lat++;
        end
        check("done_timeout", 32'(lat < 300), 32'd1);
        check("vec_zero_in_done", 32'(m_vec), 32'd0);
        check("busy_low_in_done", 32'(m_busy), 32'd0);
    endtask

    int lat, busy_n;
    logic [23:0] seq;

    initial begin
        rst_n  = 1'b0;
        start2 = 1'b0;
        start0 = 1'b0;
        fault  = 0;
        sel0   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy2), 32'd0);
        check("rst_done", 32'(done2), 32'd0);
        check("rst_pass", 32'(pass2), 32'd0);
        check("rst_err", 32'(err2), 32'd0);
        check("rst_fev", 32'(fev2), 32'd0);
        check("rst_vec", 32'({ina2, inb2, cin2}), 32'd0);
        rst_n = 1'b1;

        // correct DUT, SETTLE=2
        run_sweep(0, lat, busy_n, seq);
        check("s2_latency", 32'(lat), 32'd32);
        check("s2_busy_cycles", 32'(busy_n), 32'd32);
        check("s2_vec_order", 32'(seq), 32'(24'o01234567));
        @(negedge clk);
        check("s2_done_pulse", 32'(done2), 32'd0);
        check("s2_pass", 32'(pass2), 32'd1);
        check("s2_err", 32'(err2), 32'd0);

        // cout stuck-at-0: vectors 3,5,6,7 wrong
        fault = 1;
        run_sweep(0, lat, busy_n, seq);
        @(negedge clk);
        check("cout0_err", 32'(err2), 32'd4);
        check("cout0_fev", 32'(fev2), 32'b011);
        check("cout0_pass", 32'(pass2), 32'd0);
        repeat (3) @(negedge clk);
        check("idle_hold_err", 32'(err2), 32'd4);
        check("idle_hold_fev", 32'(fev2), 32'b011);

        // sum inverted: every vector wrong; then a clean sweep recovers
        fault = 2;
        run_sweep(0, lat, busy_n, seq);
        @(negedge clk);
        check("suminv_err", 32'(err2), 32'd8);
        check("suminv_fev", 32'(fev2), 32'd0);
        check("suminv_pass", 32'(pass2), 32'd0);
        fault = 0;
        run_sweep(0, lat, busy_n, seq);
        @(negedge clk);
        check("recover_err", 32'(err2), 32'd0);
        check("recover_pass", 32'(pass2), 32'd1);

        // reset during SETTLE of vector 4, with a fault so state is non-trivial
        fault = 1;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        begin
            int guard = 0;
            while ({ina2, inb2, cin2} != 3'b100 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check("reach_vec4", 32'(guard < 100), 32'd1);
        end
        @(negedge clk);  // now in SETTLE of vector 4
        check("pre_rst_err", 32'(err2), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy2), 32'd0);
        check("midrst_vec", 32'({ina2, inb2, cin2}), 32'd0);
        check("midrst_err", 32'(err2), 32'd0);
        check("midrst_fev", 32'(fev2), 32'd0);
        check("midrst_done", 32'(done2), 32'd0);
        repeat (2) @(negedge clk);
        check("midrst_stays_idle", 32'(busy2), 32'd0);
        fault = 0;
        run_sweep(0, lat, busy_n, seq);
        check("post_rst_latency", 32'(lat), 32'd32);
        check("post_rst_order", 32'(seq), 32'(24'o01234567));
        @(negedge clk);
        check("post_rst_pass", 32'(pass2), 32'd1);

        // start held high: ignored while busy/DONE, then re-arms from IDLE
        fault = 2;
        run_sweep(1, lat, busy_n, seq);
        check("hold_latency", 32'(lat), 32'd32);
        check("hold_order", 32'(seq), 32'(24'o01234567));
        check("hold_err_at_done", 32'(err2), 32'd8);
        fault = 0;
        @(negedge clk);  // IDLE, start sampled here
        check("hold_idle_busy", 32'(busy2), 32'd0);
        check("hold_idle_done", 32'(done2), 32'd0);
        @(negedge clk);
        start2 = 1'b0;
        check("hold_restart_busy", 32'(busy2), 32'd1);
        check("hold_restart_err", 32'(err2), 32'd0);
        check("hold_restart_vec", 32'({ina2, inb2, cin2}), 32'd0);
        begin
            int guard = 0;
            while (!done2 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check("hold_second_done", 32'(guard < 100), 32'd1);
        end
        @(negedge clk);
        check("hold_second_pass", 32'(pass2), 32'd1);

        // SETTLE=0 instance
        sel0 = 1'b1;
        fault = 0;
        run_sweep(0, lat, busy_n, seq);
        check("s0_latency", 32'(lat), 32'd16);
        check("s0_busy_cycles", 32'(busy_n), 32'd16);
        check("s0_vec_order", 32'(seq), 32'(24'o01234567));
        @(negedge clk);
        check("s0_pass", 32'(m_pass), 32'd1);
        check("s0_err", 32'(m_err), 32'd0);
        fault = 1;
        run_sweep(0, lat, busy_n, seq);
        @(negedge clk);
        check("s0_cout0_err", 32'(m_err), 32'd4);
        check("s0_cout0_fev", 32'(m_fev), 32'b011);
        check("s0_cout0_pass", 32'(m_pass), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
